dlx_instr_encoder: RTL and testbench
====================================

Name: dlx_instr_encoder

Overview:
Inverse of the DLX control decoder: accepts field-level instruction requests (format, opcode, func, register numbers, immediate) and packs them into 32-bit DLX instruction words. It rejects illegal opcode/format combinations. Encoded words are buffered in a small FIFO and emitted with a word-aligned instruction-memory address, so test/boot logic can stream programs into imem at one word per cycle.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, >=2)
ADDR_W, 16, width of instruction address counter (byte address)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request
in_fmt  in  2  0=R, 1=I, 2=J, 3=reserved
in_op  in  6  opcode, placed in [31:26]
in_func  in  11  R-type function, placed in [10:0]
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2 (R-type only)
in_imm  in  26  immediate; I uses [15:0], J uses [25:0]
out_valid  out  1  head word valid
out_ready  in  1  consumer takes head word
out_instr  out  32  encoded word at FIFO head
out_addr  out  ADDR_W  byte address of head word
base_load  in  1  load address counter
base_addr  in  ADDR_W  new base; bits [1:0] forced to 0
err  out  1  sticky illegal-request flag
err_count  out  8  illegal requests seen, wraps at 255->0

Behaviour:
- Accept when in_valid && in_ready. in_ready = (FIFO count < DEPTH); it depends only on registered count, never on out_ready.
- Encoding:
  - R: {op, rs1, rs2, rd, func}.
  - I: {op, rs1, rd, imm[15:0]}; rd goes in [20:16].
  - J: {op, imm[25:0]}.
  - No sign extension is done here.
- Legality:
  - R requires op in {0,1}.
  - J requires op in {2,3}.
  - I requires op not in {0,1,2,3}.
  - fmt 3 is always illegal.
- Illegal request: still handshaken (consumed), nothing pushed, err<=1, err_count+=1.
- Latency: an accepted legal word is visible on out_instr/out_valid the cycle after acceptance. No combinational input-to-output path.
- FIFO: circular buffer with wrap-around pointers.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Empty: out_valid=0, and out_instr holds its last value.
- Address counter pc:
  - out_addr = pc.
  - On pop, pc <= pc+4, wrapping mod 2^ADDR_W.
  - base_load: pc <= {base_addr[ADDR_W-1:2],2'b00}. It has priority over a same-cycle pop increment; the popped word is still reported at the old pc.
- Reset, mid-stream included: FIFO flushed, and every output takes its reset value on the next edge; in-flight words are lost.
  - out_valid=0, out_instr=0, out_addr=0, in_ready=1, err=0, err_count=0.
- err is cleared only by reset.

Optional Feature:
DLX_ENC_DELAY_SLOT_EN
- Defined: each accepted legal control transfer (op 2,3,4,5,18,19) pushes the encoded word, then a nop 0x00000015 (R-type func 21) in the same cycle.
  - Both words occupy consecutive FIFO entries.
  - in_ready = (count <= DEPTH-2) for all requests.
- Undefined: one word per request; in_ready as above.

Test Plan:
- add r3,r1,r2 (fmt0, op0, func32, rd3, rs1 1, rs2 2), base_load 0x40 -> out_instr 0x00221820 at out_addr 0x0040 one cycle after accept.
- addi r5,r1,-1 (fmt1, op8, rs1 1, rd5, imm 0xFFFF) -> 0x2025FFFF; jal 0x100 (fmt2, op3) -> 0x0C000100.
- Illegal requests, popping one word between them: fmt2 op8, then fmt0 op4, then fmt3 -> each accepted, nothing emitted, err=1, err_count=3.
  - Popped word takes address N; the next legal word takes address N+4 (illegal requests do not advance pc).
- Backpressure: out_ready=0, push 4 words -> in_ready=0 after 4th. Then out_ready=1 -> 4 words drained in order at 0x40,0x44,0x48,0x4C; in_ready returns 1 the cycle after the first pop.
- Continuous push+pop at count 2 for 10 cycles -> count stays 2, no drop or duplicate. Assert reset mid-stream -> out_valid=0 and out_addr=0 next cycle.
- With DLX_ENC_DELAY_SLOT_EN: beqz r1 (fmt1, op4) -> two consecutive words 0x10200000 then 0x00000015. With count=3, DEPTH=4 -> in_ready=0.

Source files
------------

// File: rtl/dlx_enc_if.sv
// Request/response bundle between an instruction-request source and dlx_instr_encoder.
// The slave side is the encoder. The master side is the request source and imem consumer.
interface dlx_enc_if #(
   parameter int ADDR_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_fmt;
   logic [5:0]        in_op;
   logic [10:0]       in_func;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [25:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              base_load;
   logic [ADDR_W-1:0] base_addr;
   logic              err;
   logic [7:0]        err_count;

   modport master (
      output in_valid, in_fmt, in_op, in_func, in_rd, in_rs1, in_rs2, in_imm,
      output out_ready, base_load, base_addr,
      input  in_ready, out_valid, out_instr, out_addr, err, err_count
   );

   modport slave (
      input  in_valid, in_fmt, in_op, in_func, in_rd, in_rs1, in_rs2, in_imm,
      input  out_ready, base_load, base_addr,
      output in_ready, out_valid, out_instr, out_addr, err, err_count
   );
endinterface

// File: rtl/dlx_instr_encoder.sv
// Packs field-level DLX requests into 32-bit words, buffers them and emits them with a word-aligned pc.
// Define DLX_ENC_DELAY_SLOT_EN to insert a nop after every legal control transfer.
module dlx_instr_encoder #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   dlx_enc_if.slave   bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [31:0]      NOP_WORD = 32'h0000_0015;

   typedef logic [PTR_W-1:0] ptr_t;

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       mem_d [DEPTH];
   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              err_q, err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic [31:0]       word;
   logic              legal;
   logic              in_ready;
   logic              accept;
   logic              push;
   logic              push_two;
   logic              bad_req;
   logic              pop;
   logic [CNT_W-1:0]  n_push;

   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (bus.in_fmt)
         2'd0: begin
            word  = {bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_func};
            legal = (bus.in_op == 6'd0) || (bus.in_op == 6'd1);
         end
         2'd1: begin
            word  = {bus.in_op, bus.in_rs1, bus.in_rd, bus.in_imm[15:0]};
            legal = (bus.in_op > 6'd3);
         end
         2'd2: begin
            word  = {bus.in_op, bus.in_imm};
            legal = (bus.in_op == 6'd2) || (bus.in_op == 6'd3);
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

`ifdef DLX_ENC_DELAY_SLOT_EN
   logic is_ctrl;
   assign is_ctrl  = bus.in_op inside {6'd2, 6'd3, 6'd4, 6'd5, 6'd18, 6'd19};
   // Always leave room for a word plus its delay-slot nop, whatever the request is.
   assign in_ready = (count_q <= DEPTH_C - CNT_W'(2));
   assign push_two = push && is_ctrl;
`else
   assign in_ready = (count_q < DEPTH_C);
   assign push_two = 1'b0;
`endif

   assign accept  = bus.in_valid && in_ready;
   assign push    = accept && legal;
   assign bad_req = accept && !legal;
   assign pop     = (count_q != '0) && bus.out_ready;
   assign n_push  = push_two ? CNT_W'(2) : (push ? CNT_W'(1) : CNT_W'(0));

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + ptr_t'(1);
         if (push_two) begin
            mem_d[wr_ptr_q + ptr_t'(1)] = NOP_WORD;
            wr_ptr_d                    = wr_ptr_q + ptr_t'(2);
         end
      end
      rd_ptr_d = pop ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;
      count_d  = count_q + n_push - {{(CNT_W-1){1'b0}}, pop};
      // Head register holds its last value once the buffer runs empty.
      instr_d  = (count_d != '0) ? mem_d[rd_ptr_d] : instr_q;

      if (bus.base_load)
         pc_d = {bus.base_addr[ADDR_W-1:2], 2'b00};
      else if (pop)
         pc_d = pc_q + ADDR_W'(4);
      else
         pc_d = pc_q;

      err_d     = err_q | bad_req;
      err_cnt_d = err_cnt_q + {7'd0, bad_req};
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         instr_q   <= '0;
         pc_q      <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = instr_q;
   assign bus.out_addr  = pc_q;
   assign bus.err       = err_q;
   assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_dlx_instr_encoder.sv
// Directed bench for dlx_instr_encoder (DEPTH=4, ADDR_W=16), both with and without DLX_ENC_DELAY_SLOT_EN.
module tb_dlx_instr_encoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

`ifdef DLX_ENC_DELAY_SLOT_EN
   localparam int CAP = 3;
`else
   localparam int CAP = 4;
`endif

   always #5 clk = ~clk;

   dlx_enc_if #(.ADDR_W(16)) bus ();

   dlx_instr_encoder #(.DEPTH(4), .ADDR_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // add rd,r1,r2: op 0, rs1 1, rs2 2, func 32
   function automatic logic [31:0] add_word(input logic [4:0] rd);
      return {6'd0, 5'd1, 5'd2, rd, 11'd32};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_fmt    = 2'd0;
      bus.in_op     = 6'd0;
      bus.in_func   = 11'd0;
      bus.in_rd     = 5'd0;
      bus.in_rs1    = 5'd0;
      bus.in_rs2    = 5'd0;
      bus.in_imm    = 26'd0;
      bus.out_ready = 1'b0;
      bus.base_load = 1'b0;
      bus.base_addr = 16'd0;
   endtask

   task automatic drive_req(input logic [1:0] fmt, input logic [5:0] op, input logic [10:0] func,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [25:0] imm);
      bus.in_valid = 1'b1;
      bus.in_fmt   = fmt;
      bus.in_op    = op;
      bus.in_func  = func;
      bus.in_rd    = rd;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      bus.in_imm   = imm;
   endtask

   task automatic do_reset(input logic [15:0] base);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.base_load = 1'b1;
      bus.base_addr = base;
      tick();
      bus.base_load = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", bus.out_instr); end
      total++; if (bus.out_addr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.out_addr); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.in_ready); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.err); end
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL rst_errcnt got=%0d want=0", bus.err_count); end
   endtask

   task automatic test_encode();
      bus.base_load = 1'b1;
      bus.base_addr = 16'h0043;
      tick();
      bus.base_load = 1'b0;
      total++; if (bus.out_addr !== 16'h0040) begin bad++; $display("FAIL base_align got=%h want=0040", bus.out_addr); end
      drive_req(2'd0, 6'd0, 11'd32, 5'd3, 5'd1, 5'd2, 26'd0);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.out_instr !== 32'h00221820) begin bad++; $display("FAIL add_instr got=%h want=00221820", bus.out_instr); end
      total++; if (bus.out_addr !== 16'h0040) begin bad++; $display("FAIL add_addr got=%h want=0040", bus.out_addr); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.out_instr !== 32'h00221820) begin bad++; $display("FAIL empty_hold got=%h want=00221820", bus.out_instr); end
      total++; if (bus.out_addr !== 16'h0044) begin bad++; $display("FAIL pc_inc got=%h want=0044", bus.out_addr); end
      drive_req(2'd1, 6'd8, 11'd0, 5'd5, 5'd1, 5'd0, 26'h000FFFF);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_instr !== 32'h2025FFFF) begin bad++; $display("FAIL addi_instr got=%h want=2025ffff", bus.out_instr); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      drive_req(2'd2, 6'd3, 11'd0, 5'd0, 5'd0, 5'd0, 26'h0000100);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_instr !== 32'h0C000100) begin bad++; $display("FAIL jal_instr got=%h want=0c000100", bus.out_instr); end
      total++; if (bus.out_addr !== 16'h0048) begin bad++; $display("FAIL jal_addr got=%h want=0048", bus.out_addr); end
      bus.out_ready = 1'b1;
      tick();
`ifdef DLX_ENC_DELAY_SLOT_EN
      total++; if (bus.out_instr !== 32'h00000015) begin bad++; $display("FAIL jal_nop got=%h want=00000015", bus.out_instr); end
      total++; if (bus.out_addr !== 16'h004C) begin bad++; $display("FAIL jal_nop_addr got=%h want=004c", bus.out_addr); end
      tick();
`endif
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL jal_drained got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_illegal();
      do_reset(16'h0100);
      drive_req(2'd0, 6'd0, 11'd32, 5'd7, 5'd1, 5'd2, 26'd0);
      tick();
      drive_req(2'd2, 6'd8, 11'd0, 5'd0, 5'd0, 5'd0, 26'h0000100);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ill1_err got=%b want=1", bus.err); end
      total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL ill1_cnt got=%0d want=1", bus.err_count); end
      total++; if (bus.out_instr !== add_word(5'd7)) begin bad++; $display("FAIL ill1_head got=%h want=%h", bus.out_instr, add_word(5'd7)); end
      total++; if (bus.out_addr !== 16'h0100) begin bad++; $display("FAIL ill_addr_n got=%h want=0100", bus.out_addr); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ill1_nopush got=%b want=0", bus.out_valid); end
      drive_req(2'd0, 6'd4, 11'd32, 5'd3, 5'd1, 5'd2, 26'd0);
      tick();
      total++; if (bus.err_count !== 8'd2) begin bad++; $display("FAIL ill2_cnt got=%0d want=2", bus.err_count); end
      drive_req(2'd3, 6'd0, 11'd32, 5'd3, 5'd1, 5'd2, 26'd0);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.err_count !== 8'd3) begin bad++; $display("FAIL ill3_cnt got=%0d want=3", bus.err_count); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ill3_nopush got=%b want=0", bus.out_valid); end
      drive_req(2'd1, 6'd8, 11'd0, 5'd5, 5'd1, 5'd0, 26'h000FFFF);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_instr !== 32'h2025FFFF) begin bad++; $display("FAIL ill_next_instr got=%h want=2025ffff", bus.out_instr); end
      total++; if (bus.out_addr !== 16'h0104) begin bad++; $display("FAIL ill_next_addr got=%h want=0104", bus.out_addr); end
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset(16'h0040);
      for (int i = 0; i < CAP; i++) begin
         drive_req(2'd0, 6'd0, 11'd32, 5'(i + 1), 5'd1, 5'd2, 26'd0);
         tick();
         total++;
         if (bus.in_ready !== (i < CAP - 1)) begin
            bad++; $display("FAIL bp_ready[%0d] got=%b want=%b", i, bus.in_ready, (i < CAP - 1));
         end
      end
      // Held request while full must not be taken.
      drive_req(2'd0, 6'd0, 11'd32, 5'd31, 5'd1, 5'd2, 26'd0);
      tick();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < CAP; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== add_word(5'(i + 1))) begin
            bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, bus.out_instr, add_word(5'(i + 1)));
         end
         total++;
         if (bus.out_addr !== 16'(16'h0040 + 4 * i)) begin
            bad++; $display("FAIL bp_addr[%0d] got=%h want=%h", i, bus.out_addr, 16'(16'h0040 + 4 * i));
         end
         tick();
         if (i == 0) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", bus.in_ready); end
         end
      end
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q[$];
      logic [31:0] tmp;
      do_reset(16'h0200);
      for (int i = 1; i <= 2; i++) begin
         drive_req(2'd0, 6'd0, 11'd32, 5'(i), 5'd1, 5'd2, 26'd0);
         tick();
         q.push_back(add_word(5'(i)));
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive_req(2'd0, 6'd0, 11'd32, 5'(k + 3), 5'd1, 5'd2, 26'd0);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== q[0]) begin
            bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", k, bus.out_instr, q[0]);
         end
         total++;
         if (bus.out_addr !== 16'(16'h0200 + 4 * k)) begin
            bad++; $display("FAIL b2b_addr[%0d] got=%h want=%h", k, bus.out_addr, 16'(16'h0200 + 4 * k));
         end
         q.push_back(add_word(5'(k + 3)));
         tmp = q.pop_front();
         tick();
      end
      bus.in_valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== q[0]) begin
            bad++; $display("FAIL b2b_tail[%0d] got=%h want=%h", j, bus.out_instr, q[0]);
         end
         tmp = q.pop_front();
         tick();
      end
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_count got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_mid_reset();
      do_reset(16'h0300);
      drive_req(2'd3, 6'd0, 11'd0, 5'd0, 5'd0, 5'd0, 26'd0);
      tick();
      drive_req(2'd0, 6'd0, 11'd32, 5'd4, 5'd1, 5'd2, 26'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.out_addr !== 16'h0) begin bad++; $display("FAIL mrst_addr got=%h want=0", bus.out_addr); end
      total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL mrst_instr got=%h want=0", bus.out_instr); end
      total++; if (bus.err !== 1'b0 || bus.err_count !== 8'd0) begin bad++; $display("FAIL mrst_err got=%b/%0d want=0/0", bus.err, bus.err_count); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%b want=1", bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_lost got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_delay_slot();
      do_reset(16'h0000);
      drive_req(2'd1, 6'd4, 11'd0, 5'd0, 5'd1, 5'd0, 26'd0);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_instr !== 32'h10200000) begin bad++; $display("FAIL beqz_instr got=%h want=10200000", bus.out_instr); end
`ifdef DLX_ENC_DELAY_SLOT_EN
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ds_ready2 got=%b want=1", bus.in_ready); end
      drive_req(2'd0, 6'd0, 11'd32, 5'd9, 5'd1, 5'd2, 26'd0);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ds_ready3 got=%b want=0", bus.in_ready); end
      bus.out_ready = 1'b1;
      tick();
      total++; if (bus.out_instr !== 32'h00000015) begin bad++; $display("FAIL ds_nop got=%h want=00000015", bus.out_instr); end
      total++; if (bus.out_addr !== 16'h0004) begin bad++; $display("FAIL ds_nop_addr got=%h want=0004", bus.out_addr); end
      tick();
      total++; if (bus.out_instr !== add_word(5'd9)) begin bad++; $display("FAIL ds_next got=%h want=%h", bus.out_instr, add_word(5'd9)); end
      tick();
`else
      bus.out_ready = 1'b1;
      tick();
`endif
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ds_drained got=%b want=0", bus.out_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      test_reset();
      test_encode();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_delay_slot();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
